dsi_reg_slave: RTL and testbench

//  - Write-responder (slave) end of the DSI controller register bus; accepts AW/W channel writes.
//  - Stores the writes in a 32-bit register bank and drives the bank onto flat config outputs.
//  - Consumed by the DSI timing/packet logic (HSA/HBP/HACT/VSA/VBP/VACT, CTRL).

---
 rtl/dsi_reg_slave.sv | 139 +++++++++++++
 tb/tb_dsi_reg_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_reg_slave.sv
// DSI controller register bank: AW/W write responder driving flat config outputs, 1-cycle commit.
// Define DSI_REG_READ_EN to add the AR/R read channel.
module dsi_reg_slave #(
  parameter int          ADDR_W   = 8,
  parameter int          REG_NUM  = 24,
  parameter logic [31:0] ID_VALUE = 32'h4453_4901
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [31:0]           wdata_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic                  bvalid_o,
  output logic [1:0]            bresp_o,
  input  logic                  bready_i,
`ifdef DSI_REG_READ_EN
  input  logic [ADDR_W-1:0]     araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [31:0]           rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
`endif
  output logic [REG_NUM*32-1:0] cfg_o,
  output logic                  wr_stb_o,
  output logic [4:0]            wr_idx_o
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int BANK_W = $clog2(REG_NUM);

  logic              r_aw_full;
  logic [ADDR_W-1:0] r_aw_addr;
  logic              r_w_full;
  logic [31:0]       r_w_data;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_wr_stb;
  logic [4:0]        r_wr_idx;
  logic [31:0]       r_bank [REG_NUM];

  logic [IDX_W-1:0]  w_aw_idx;
  logic              w_wr_ok;
  logic              w_commit;

  assign w_aw_idx = r_aw_addr[ADDR_W-1:2];
  // Word 0 is the read-only ID; misaligned or out-of-range addresses never alias.
  assign w_wr_ok  = (r_aw_addr[1:0] == 2'b00) && (32'(w_aw_idx) < REG_NUM) && (w_aw_idx != '0);
  assign w_commit = r_aw_full && r_w_full && (!r_bvalid || bready_i);

  assign awready_o = ~r_aw_full;
  assign wready_o  = ~r_w_full;
  assign bvalid_o  = r_bvalid;
  assign bresp_o   = r_bresp;
  assign wr_stb_o  = r_wr_stb;
  assign wr_idx_o  = r_wr_idx;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_wr_stb  <= 1'b0;
      r_wr_idx  <= '0;
      for (int k = 0; k < REG_NUM; k++) begin
        r_bank[k] <= (k == 0) ? ID_VALUE : 32'h0;
      end
    end else begin
      r_wr_stb <= w_commit && w_wr_ok;
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
        if (w_wr_ok) begin
          r_bank[w_aw_idx[BANK_W-1:0]] <= r_w_data;
          r_wr_idx                     <= w_aw_idx[4:0];
        end
      end else begin
        if (awvalid_i && !r_aw_full) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= awaddr_i;
        end
        if (wvalid_i && !r_w_full) begin
          r_w_full <= 1'b1;
          r_w_data <= wdata_i;
        end
        if (bready_i) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < REG_NUM; g++) begin : g_cfg
      assign cfg_o[g*32 +: 32] = r_bank[g];
    end
  endgenerate

`ifdef DSI_REG_READ_EN
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_rd_ok;

  assign w_ar_idx  = araddr_i[ADDR_W-1:2];
  assign w_rd_ok   = (araddr_i[1:0] == 2'b00) && (32'(w_ar_idx) < REG_NUM);
  assign arready_o = ~r_rvalid;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;

  // Bank is sampled before any same-edge commit lands, so reads see the old value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (arvalid_i && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_ok ? r_bank[w_ar_idx[BANK_W-1:0]] : 32'h0;
      r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
    end else if (rready_i) begin
      r_rvalid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dsi_reg_slave.sv
// Scoreboard bench for dsi_reg_slave: directed scenarios plus randomized writes against a word-array model.
module tb_dsi_reg_slave;
  localparam int          ADDR_W   = 8;
  localparam int          REG_NUM  = 24;
  localparam logic [31:0] ID_VALUE = 32'h4453_4901;

  logic                  clk_i = 1'b0;
  logic                  rst_n_i = 1'b0;
  logic [ADDR_W-1:0]     awaddr_i = '0;
  logic                  awvalid_i = 1'b0;
  logic                  awready_o;
  logic [31:0]           wdata_i = '0;
  logic                  wvalid_i = 1'b0;
  logic                  wready_o;
  logic                  bvalid_o;
  logic [1:0]            bresp_o;
  logic                  bready_i = 1'b1;
  logic [REG_NUM*32-1:0] cfg_o;
  logic                  wr_stb_o;
  logic [4:0]            wr_idx_o;
`ifdef DSI_REG_READ_EN
  logic [ADDR_W-1:0]     araddr_i = '0;
  logic                  arvalid_i = 1'b0;
  logic                  arready_o;
  logic [31:0]           rdata_o;
  logic [1:0]            rresp_o;
  logic                  rvalid_o;
  logic                  rready_i = 1'b1;
`endif

  dsi_reg_slave #(.ADDR_W(ADDR_W), .REG_NUM(REG_NUM), .ID_VALUE(ID_VALUE)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bvalid_o(bvalid_o), .bresp_o(bresp_o), .bready_i(bready_i),
`ifdef DSI_REG_READ_EN
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
`endif
    .cfg_o(cfg_o), .wr_stb_o(wr_stb_o), .wr_idx_o(wr_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  bq [$];
  logic [36:0] wq [$];
  logic [31:0] model [REG_NUM];
  bit          rand_bready = 1'b0;

  function automatic logic [31:0] word(input int k);
    return cfg_o[k*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic bit addr_ok(input logic [7:0] a);
    int i;
    i = int'(a) / 4;
    return (int'(a) % 4 == 0) && (i < REG_NUM) && (i != 0);
  endfunction

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
    if (addr_ok(a)) begin
      bq.push_back(2'b00);
      wq.push_back({5'(int'(a) / 4), d});
      model[int'(a) / 4] = d;
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    int n;
    bit ta, tw;
    n = 0;
    expect_write(a, d);
    awaddr_i = a; wdata_i = d; awvalid_i = 1'b1; wvalid_i = 1'b1;
    while (awvalid_i || wvalid_i) begin
      ta = awvalid_i && awready_o;
      tw = wvalid_i && wready_o;
      if (rand_bready) bready_i = ($urandom_range(0, 2) != 0);
      @(posedge clk_i); #1;
      if (ta) awvalid_i = 1'b0;
      if (tw) wvalid_i = 1'b0;
      n++;
      if (n > 200) begin
        flag("write_handshake_timeout");
        awvalid_i = 1'b0; wvalid_i = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

`ifdef DSI_REG_READ_EN
  task automatic do_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n;
    n = 0;
    araddr_i = a; arvalid_i = 1'b1;
    while (!arready_o && n < 50) begin step(); n++; end
    step();
    arvalid_i = 1'b0;
    chk("rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("rdata", rdata_o, ed);
    chk("rresp", {30'd0, rresp_o}, {30'd0, er});
    step();
  endtask
`endif

  // Scoreboard monitor: consumes expectations whenever the DUT presents a response or a strobe.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (bvalid_o && bready_i) begin
        if (bq.size() == 0) flag("b_unexpected");
        else chk("bresp", {30'd0, bresp_o}, {30'd0, bq.pop_front()});
      end
      if (wr_stb_o) begin
        if (wq.size() == 0) flag("wr_stb_unexpected");
        else begin
          logic [36:0] e;
          e = wq.pop_front();
          chk("wr_idx", {27'd0, wr_idx_o}, {27'd0, e[36:32]});
          chk("wr_word", word(int'(e[36:32])), e[31:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  logic [31:0] tbl [8];
  logic [7:0]  bad [3];
  logic [7:0]  ra;

  initial begin
    tbl = '{32'h0000_0010, 32'h0000_0006, 32'h0000_0020, 32'h0000_0780,
            32'h0000_0002, 32'h0000_0004, 32'h0000_0438, 32'h0000_0001};
    bad = '{8'h42, 8'h00, 8'h60};
    for (int k = 0; k < REG_NUM; k++) model[k] = (k == 0) ? ID_VALUE : 32'h0;

    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    step();
    chk("rst_awready", {31'd0, awready_o}, 32'd1);
    chk("rst_wready", {31'd0, wready_o}, 32'd1);
    chk("rst_bvalid", {31'd0, bvalid_o}, 32'd0);
    chk("rst_wr_stb", {31'd0, wr_stb_o}, 32'd0);
    chk("rst_wr_idx", {27'd0, wr_idx_o}, 32'd0);
    chk("rst_word16", word(16), 32'h0);
    chk("rst_word0", word(0), ID_VALUE);

    // Same-cycle AW/W: commit exactly one edge after the handshake.
    do_write(8'h40, 32'h0000_14C8);
    chk("t2_no_early_stb", {31'd0, wr_stb_o}, 32'd0);
    step();
    chk("t2_stb", {31'd0, wr_stb_o}, 32'd1);
    chk("t2_idx", {27'd0, wr_idx_o}, 32'd16);
    chk("t2_word16", word(16), 32'h0000_14C8);
    chk("t2_bvalid", {31'd0, bvalid_o}, 32'd1);
    chk("t2_bresp", {30'd0, bresp_o}, 32'd0);
    step();

    // W leads AW by three cycles.
    expect_write(8'h18, 32'h0000_000A);
    wdata_i = 32'h0000_000A; wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_wready_low", {31'd0, wready_o}, 32'd0);
      chk("t3_awready_high", {31'd0, awready_o}, 32'd1);
      step();
    end
    awaddr_i = 8'h18; awvalid_i = 1'b1;
    step();
    awvalid_i = 1'b0;
    step();
    chk("t3_stb", {31'd0, wr_stb_o}, 32'd1);
    chk("t3_word6", word(6), 32'h0000_000A);
    step();

    // Misaligned, read-only ID and out-of-range writes.
    for (int i = 0; i < 3; i++) begin
      do_write(bad[i], 32'hFFFF_FFFF);
      step();
      chk("t4_no_stb", {31'd0, wr_stb_o}, 32'd0);
      chk("t4_bresp", {30'd0, bresp_o}, 32'd2);
      chk("t4_word0", word(0), ID_VALUE);
    end
    step();

    // Stall: B slot held, second write parks in the slots.
    bready_i = 1'b0;
    do_write(8'h20, 32'h1111_2222);
    do_write(8'h24, 32'h3333_4444);
    for (int i = 0; i < 3; i++) begin
      chk("t5_awready_low", {31'd0, awready_o}, 32'd0);
      chk("t5_wready_low", {31'd0, wready_o}, 32'd0);
      chk("t5_no_stb", {31'd0, wr_stb_o}, 32'd0);
      chk("t5_word9_held", word(9), 32'h0);
      step();
    end
    bready_i = 1'b1;
    step();
    chk("t5_bvalid_kept", {31'd0, bvalid_o}, 32'd1);
    chk("t5_stb", {31'd0, wr_stb_o}, 32'd1);
    chk("t5_word9", word(9), 32'h3333_4444);
    step();

    // Timing table.
    for (int i = 0; i < 8; i++) do_write(8'(8'h40 + 4 * i), tbl[i]);
    do_write(8'h18, 32'h0000_000A);
    repeat (3) step();
    for (int i = 0; i < 8; i++) chk("t6_table", word(16 + i), tbl[i]);
    chk("t6_word6", word(6), 32'h0000_000A);
`ifdef DSI_REG_READ_EN
    do_read(8'h00, ID_VALUE, 2'b00);
    do_read(8'h44, 32'h0000_0006, 2'b00);
    do_read(8'h62, 32'h0, 2'b10);
`endif

    // Randomized writes with a toggling B-channel ready.
    rand_bready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) ra = {1'b0, 5'($urandom_range(0, 23)), 2'b00};
      else ra = 8'($urandom_range(0, 255));
      do_write(ra, $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    rand_bready = 1'b0;
    bready_i = 1'b1;
    repeat (5) step();
    for (int k = 0; k < REG_NUM; k++) chk("final_word", word(k), model[k]);
    chk("bq_drained", bq.size(), 32'd0);
    chk("wq_drained", wq.size(), 32'd0);

    // Reset with a pending response and a half-filled slot.
    bready_i = 1'b0;
    do_write(8'h44, 32'hDEAD_BEEF);
    step();
    awaddr_i = 8'h48; awvalid_i = 1'b1;
    step();
    awvalid_i = 1'b0;
    chk("t7_aw_parked", {31'd0, awready_o}, 32'd0);
    chk("t7_bvalid_pending", {31'd0, bvalid_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    bq.delete();
    for (int k = 0; k < REG_NUM; k++) model[k] = (k == 0) ? ID_VALUE : 32'h0;
    chk("t7_bvalid", {31'd0, bvalid_o}, 32'd0);
    chk("t7_awready", {31'd0, awready_o}, 32'd1);
    chk("t7_wready", {31'd0, wready_o}, 32'd1);
    chk("t7_word17", word(17), model[17]);
    chk("t7_word0", word(0), model[0]);
    step();
    rst_n_i = 1'b1;
    bready_i = 1'b1;
    repeat (2) step();
    chk("t7_no_commit", {31'd0, wr_stb_o}, 32'd0);
    chk("t7_word16", word(16), model[16]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
